// File: rtl/seq_stream_ctrl_if.sv
// Host-side bundle for seq_stream_ctrl: start/busy/done handshake, stream word and results.
// With SEQ_CTRL_HITVEC_EN defined, the per-index hit vector is carried as well.
interface seq_stream_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] first_hit;
  logic             hit_any;
`ifdef SEQ_CTRL_HITVEC_EN
  logic [WIDTH-1:0] hit_vec;

  modport master (
    output start, data_in, len,
    input  busy, done, hit_count, first_hit, hit_any, hit_vec
  );
  modport slave (
    input  start, data_in, len,
    output busy, done, hit_count, first_hit, hit_any, hit_vec
  );
`else
  modport master (
    output start, data_in, len,
    input  busy, done, hit_count, first_hit, hit_any
  );
  modport slave (
    input  start, data_in, len,
    output busy, done, hit_count, first_hit, hit_any
  );
`endif
endinterface

// File: rtl/seq_stream_ctrl.sv
// Streams a loaded word MSB-first into a serial sequence detector and tallies its hits.
// Optional SEQ_CTRL_HITVEC_EN adds a per-stream-index hit vector output.
module seq_stream_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  seq_stream_ctrl_if.slave host,
  output logic             det_clr,
  output logic             det_en,
  output logic             det_x,
  input  logic             det_y
);
  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [CNT_W-1:0] eff_len_reg;
  logic [CNT_W-1:0] hit_count_reg;
  logic [CNT_W-1:0] first_hit_reg;
  logic             hit_any_reg;
  logic [CNT_W-1:0] len_eff;
  logic             accept;
  logic             last_bit;
  logic             hit;
  logic             busy;
  logic             done;

  assign accept   = (state_reg == IDLE) && host.start;
  assign last_bit = (idx_reg == eff_len_reg - CNT_W'(1));
  assign hit      = (state_reg == SHIFT) && det_y;
  // A zero or oversized length means "stream the whole word".
  assign len_eff  = (host.len == '0 || host.len > WIDTH_C) ? WIDTH_C : host.len;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    det_clr    = 1'b0;
    det_en     = 1'b0;
    det_x      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.start) state_next = CLR;
      end
      CLR: begin
        busy       = 1'b1;
        det_clr    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy   = 1'b1;
        det_en = 1'b1;
        det_x  = shift_reg[WIDTH-1];
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg     <= '0;
      idx_reg       <= '0;
      eff_len_reg   <= '0;
      hit_count_reg <= '0;
      first_hit_reg <= '0;
      hit_any_reg   <= 1'b0;
    end else if (accept) begin
      shift_reg     <= host.data_in;
      idx_reg       <= '0;
      eff_len_reg   <= len_eff;
      hit_count_reg <= '0;
      first_hit_reg <= '0;
      hit_any_reg   <= 1'b0;
    end else if (state_reg == SHIFT) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      idx_reg   <= idx_reg + CNT_W'(1);
      if (det_y) begin
        if (hit_count_reg != '1) hit_count_reg <= hit_count_reg + CNT_W'(1);
        if (!hit_any_reg) begin
          first_hit_reg <= idx_reg;
          hit_any_reg   <= 1'b1;
        end
      end
    end
  end

  assign host.busy      = busy;
  assign host.done      = done;
  assign host.hit_count = hit_count_reg;
  assign host.first_hit = first_hit_reg;
  assign host.hit_any   = hit_any_reg;

`ifdef SEQ_CTRL_HITVEC_EN
  logic [WIDTH-1:0] hit_vec_reg;
  logic [WIDTH-1:0] hit_set;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_hit_set
      assign hit_set[gi] = hit && (idx_reg == CNT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || accept) hit_vec_reg <= '0;
    else                 hit_vec_reg <= hit_vec_reg | hit_set;
  end

  assign host.hit_vec = hit_vec_reg;
`endif
endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
Sequencer for the serial-input sequence-detector circuit. It loads a parallel word and clears the detector. It then streams the word MSB-first onto the detector's x input, one bit per clock, and samples the detector's y output every cycle. It reports hit count and first-hit position to the host through a start/busy/done handshake.

Parameters:
WIDTH, 16, maximum stream length in bits; width of data_in.
CNT_W, 5, width of len, hit_count and first_hit; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
data_in  input  WIDTH  word to stream; bit WIDTH-1 is sent first.
len  input  CNT_W  number of bits to stream; 0 or >WIDTH means WIDTH.
busy  output  1  high in CLR and SHIFT states.
done  output  1  one-cycle pulse in DONE state.
hit_count  output  CNT_W  number of cycles with det_y=1 during SHIFT.
first_hit  output  CNT_W  0-based stream index of the first hit; 0 if none.
hit_any  output  1  at least one hit seen in the current or last run.
det_clr  output  1  synchronous clear to the detector; high only in CLR.
det_en  output  1  high in SHIFT; marks det_x valid.
det_x  output  1  serial bit to the detector; 0 outside SHIFT.
det_y  input  1  detector output for the current det_x (Mealy); sampled at the edge ending each SHIFT cycle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; busy, done, det_clr, det_en, det_x, hit_any = 0; hit_count, first_hit = 0; shift register and index cleared.
- Reset mid-run aborts immediately. No done pulse is produced.
- States: IDLE -> CLR -> SHIFT -> DONE -> IDLE.
- IDLE, start=1 at an edge:
  - shift register <= data_in; eff_len <= (len==0 || len>WIDTH) ? WIDTH : len; idx <= 0.
  - hit_count, first_hit, hit_any <= 0; next state CLR.
- CLR: lasts exactly 1 cycle; det_clr=1, det_en=0, det_x=0; next state SHIFT.
- SHIFT: lasts eff_len cycles. Each cycle det_en=1 and det_x = shift register MSB. At each edge:
  - If det_y=1: hit_count+1 (saturate at all-ones).
  - If det_y=1 and hit_any=0: first_hit <= idx, hit_any <= 1.
  - Shift register shifts left, filling with 0; idx+1.
  - If idx == eff_len-1: next state DONE.
- DONE: lasts 1 cycle; done=1, busy=0; next state IDLE.
- Results hold until the next accepted start.
- Latency: start accepted at edge k. CLR occupies cycle k+1. SHIFT occupies cycles k+2..k+1+N. done is high in cycle k+2+N.
- start while busy or in DONE is ignored. It is not queued.
- data_in and len are sampled only at acceptance; later changes have no effect.
- det_y is ignored outside SHIFT.

Optional Feature:
SEQ_CTRL_HITVEC_EN
- Defined: adds output hit_vec[WIDTH-1:0].
  - Cleared at start acceptance and on reset.
  - Bit i is set when det_y=1 at stream index i.
  - Bits at and above eff_len stay 0.
  - Held until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
Bench stub detector: det_y = det_x & det_en, so hits equal the ones streamed.
- Reset, then start with data_in=16'hB000, len=4: det_x stream 1,0,1,1 in cycles k+2..k+5; done in cycle k+6; hit_count=3, first_hit=0, hit_any=1; hit_vec=16'h000D.
- data_in=16'h0F00, len=8: hit_count=4, first_hit=4; det_clr high only in cycle k+1.
- data_in=16'hFFFF, len=0: 16 SHIFT cycles; hit_count=16, first_hit=0; done in cycle k+18.
- data_in=16'h0000, len=5: hit_count=0, hit_any=0, first_hit=0; done in cycle k+7.
- start pulsed again during SHIFT and in DONE: ignored; exactly one done per accepted start; results unchanged.
- reset asserted in 3rd SHIFT cycle: next cycle IDLE with all outputs 0 and no done; a following start of 16'h8000, len=1 gives hit_count=1.
